alien_swarm_scheduler: RTL

// Sequences the alien swarm's stepping. Counts frame ticks and issues a one-cycle

---
 rtl/alien_swarm_scheduler_pkg.sv | 22 ++
 rtl/alien_swarm_scheduler_if.sv | 31 +++
 rtl/alien_swarm_scheduler_step_divider.sv | 36 +++
 rtl/alien_swarm_scheduler.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alien_swarm_scheduler_pkg.sv
// Shared definitions for the alien swarm stepping logic: motion codes
// (also used by the zig-zag motion generator) and scheduler state encoding.
package alien_swarm_scheduler_pkg;

   typedef enum logic [1:0] {
      NO_MOTION = 2'd0,
      LEFT      = 2'd1,
      RIGHT     = 2'd2,
      DOWN      = 2'd3
   } motion_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      REQ   = 3'd2,
      APPLY = 3'd3,
      HALT  = 3'd4
   } state_e;

   localparam int MOTION_W = 2;

endpackage

// File: rtl/alien_swarm_scheduler_if.sv
// Bundle between frame timing / motion generator / renderer and the swarm scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface alien_swarm_scheduler_if #(
   parameter int X_W   = 10,
   parameter int Y_W   = 10,
   parameter int CNT_W = 6
);
   import alien_swarm_scheduler_pkg::*;

   logic                frame_tick;
   logic                run;
   logic [CNT_W-1:0]    alive_count;
   logic [MOTION_W-1:0] motion_in;
   logic                step_en;
   logic                can_left;
   logic                can_right;
   logic [X_W-1:0]      swarm_x;
   logic [Y_W-1:0]      swarm_y;
   logic                invaded;

   modport master (
      output frame_tick, run, alive_count, motion_in,
      input  step_en, can_left, can_right, swarm_x, swarm_y, invaded
   );

   modport slave (
      input  frame_tick, run, alive_count, motion_in,
      output step_en, can_left, can_right, swarm_x, swarm_y, invaded
   );

endinterface

// File: rtl/alien_swarm_scheduler_step_divider.sv
// Frame-tick countdown: loads a period, decrements on request, and flags
// expiry once the count has run down to one (or was never loaded).
module alien_swarm_scheduler_step_divider #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] period,
   output logic         expire
);

   logic [W-1:0] div_q;
   logic [W-1:0] div_d;

   always_comb begin
      div_d = div_q;
      if (load) begin
         div_d = period;
      end else if (dec) begin
         div_d = div_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   assign expire = (div_q <= W'(1));

endmodule

// File: rtl/alien_swarm_scheduler.sv
// Swarm stepping sequencer: paces step requests to the motion generator from
// frame ticks, applies the returned motion to the swarm origin and flags invasion.
module alien_swarm_scheduler
   import alien_swarm_scheduler_pkg::*;
#(
   parameter int X_W        = 10,
   parameter int Y_W        = 10,
   parameter int X_START    = 288,
   parameter int Y_START    = 32,
   parameter int X_MIN      = 0,
   parameter int X_MAX      = 608,
   parameter int STEP_X     = 8,
   parameter int STEP_Y     = 16,
   parameter int Y_LIMIT    = 400,
   parameter int PERIOD_MIN = 4,
   parameter int PERIOD_MAX = 60,
   parameter int CNT_W      = 6
) (
   input logic                   clk,
   input logic                   reset,
   alien_swarm_scheduler_if.slave bus
);

   localparam int P_W = CNT_W + 1;

   localparam logic [X_W-1:0] X_MIN_N   = X_W'(X_MIN);
   localparam logic [X_W-1:0] STEP_X_N  = X_W'(STEP_X);
   localparam logic [X_W:0]   STEP_X_E  = (X_W+1)'(STEP_X);
   localparam logic [X_W:0]   X_MAX_E   = (X_W+1)'(X_MAX);
   localparam logic [X_W:0]   LEFT_TH   = (X_W+1)'(X_MIN + STEP_X);
   localparam logic [Y_W:0]   STEP_Y_E  = (Y_W+1)'(STEP_Y);
   localparam logic [Y_W:0]   Y_LIMIT_E = (Y_W+1)'(Y_LIMIT);
   localparam logic [X_W-1:0] X_RST     = X_W'(X_START);
   localparam logic [Y_W-1:0] Y_RST     = Y_W'(Y_START);
   localparam logic           CL_RST    = (X_START >= X_MIN + STEP_X);
   localparam logic           CR_RST    = (X_START + STEP_X <= X_MAX);
   localparam logic [P_W-1:0] P_MIN     = P_W'(PERIOD_MIN);
   localparam logic [P_W-1:0] P_MAX     = P_W'(PERIOD_MAX);

   state_e         state_q, state_d;
   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic           can_left_q, can_left_d;
   logic           can_right_q, can_right_d;
   logic           invaded_q, invaded_d;
   logic           step_en_q, step_en_d;

   logic           div_load;
   logic           div_dec;
   logic           div_expire;
   logic [P_W-1:0] period_sum;
   logic [P_W-1:0] period;

   motion_e        motion;
   logic [X_W:0]   x_sum;
   logic [X_W-1:0] x_dif;
   logic [Y_W:0]   y_sum;
   logic [X_W-1:0] x_new;
   logic [Y_W-1:0] y_new;
   logic           y_hit;

   function automatic logic calc_can_left(input logic [X_W-1:0] x);
      return ({1'b0, x} >= LEFT_TH);
   endfunction

   function automatic logic calc_can_right(input logic [X_W-1:0] x);
      return (({1'b0, x} + STEP_X_E) <= X_MAX_E);
   endfunction

   // One bit of headroom keeps PERIOD_MIN + alive_count from wrapping before saturation.
   assign period_sum = P_MIN + {1'b0, bus.alive_count};
   assign period     = (period_sum > P_MAX) ? P_MAX : period_sum;

   alien_swarm_scheduler_step_divider #(
      .W (P_W)
   ) u_step_divider (
      .clk    (clk),
      .reset  (reset),
      .load   (div_load),
      .dec    (div_dec),
      .period (period),
      .expire (div_expire)
   );

   assign motion = motion_e'(bus.motion_in);

   // Widened sums expose clamp and limit conditions without wrap-around.
   always_comb begin
      x_sum = {1'b0, x_q} + STEP_X_E;
      x_dif = x_q - STEP_X_N;
      y_sum = {1'b0, y_q} + STEP_Y_E;
      x_new = x_q;
      y_new = y_q;
      case (motion)
         LEFT:    x_new = ({1'b0, x_q} >= LEFT_TH) ? x_dif : X_MIN_N;
         RIGHT:   x_new = (x_sum > X_MAX_E) ? X_MAX_E[X_W-1:0] : x_sum[X_W-1:0];
         DOWN:    y_new = y_sum[Y_W] ? {Y_W{1'b1}} : y_sum[Y_W-1:0];
         default: ;
      endcase
      y_hit = ({1'b0, y_new} >= Y_LIMIT_E);
   end

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      can_left_d  = can_left_q;
      can_right_d = can_right_q;
      invaded_d   = invaded_q;
      div_load    = 1'b0;
      div_dec     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.run) begin
               state_d  = WAIT;
               div_load = 1'b1;
            end
         end
         WAIT: begin
            if (!bus.run) begin
               state_d = IDLE;
            end else if (bus.frame_tick) begin
               if (!div_expire) begin
                  div_dec = 1'b1;
               end else if (bus.alive_count != '0) begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            state_d = APPLY;
         end
         APPLY: begin
            x_d         = x_new;
            y_d         = y_new;
            can_left_d  = calc_can_left(x_new);
            can_right_d = calc_can_right(x_new);
            div_load    = 1'b1;
            if (y_hit) begin
               invaded_d = 1'b1;
               state_d   = HALT;
            end else if (bus.run) begin
               state_d = WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      step_en_d = (state_d == REQ);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         x_q         <= X_RST;
         y_q         <= Y_RST;
         can_left_q  <= CL_RST;
         can_right_q <= CR_RST;
         invaded_q   <= 1'b0;
         step_en_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         can_left_q  <= can_left_d;
         can_right_q <= can_right_d;
         invaded_q   <= invaded_d;
         step_en_q   <= step_en_d;
      end
   end

   assign bus.step_en   = step_en_q;
   assign bus.can_left  = can_left_q;
   assign bus.can_right = can_right_q;
   assign bus.swarm_x   = x_q;
   assign bus.swarm_y   = y_q;
   assign bus.invaded   = invaded_q;

endmodule
